// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit write controller driven by the CPU LCD register.
// Optional power-up init sequence is enabled by defining LCD_CTRL_INIT_SEQ_EN.
module lcd_ctrl #(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EN_HIGH   = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_reg_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        busy_o,
    output logic        overrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;
    logic        on_q;
    logic        prev_go_q;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        pend_rs_q, pend_rs_d;

    logic        req;
    logic        req_taken;
    logic        last_cycle;
    logic        launch;
    logic [7:0]  launch_data;
    logic        launch_rs;
    logic        init_step;
    logic        init_rem;
    logic [7:0]  init_word;
    logic        unused_bits;

`ifdef LCD_CTRL_INIT_SEQ_EN
    logic [2:0] init_idx_q, init_idx_d;

    assign init_rem = (init_idx_q < 3'd4);

    always_comb begin
        unique case (init_idx_q[1:0])
            2'd0:    init_word = 8'h38;
            2'd1:    init_word = 8'h0C;
            2'd2:    init_word = 8'h01;
            default: init_word = 8'h06;
        endcase
    end

    assign init_idx_d = init_step ? init_idx_q + 3'd1 : init_idx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            init_idx_q <= '0;
        end else begin
            init_idx_q <= init_idx_d;
        end
    end
`else
    assign init_rem  = 1'b0;
    assign init_word = '0;
`endif

    assign unused_bits = ^{lcd_reg_i[30:11], lcd_reg_i[9], init_step};

    assign req        = lcd_reg_i[10] ^ prev_go_q;
    assign last_cycle = (cnt_q <= 32'd1);

    function automatic logic [31:0] exec_len(input logic rs, input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) begin
            return T_EXEC_LONG;
        end
        return T_EXEC;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - 32'd1 : '0;
        data_d      = data_q;
        rs_d        = rs_q;
        ovr_d       = ovr_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        pend_rs_d   = pend_rs_q;
        req_taken   = 1'b0;
        init_step   = 1'b0;
        launch      = 1'b0;
        launch_data = '0;
        launch_rs   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (init_rem) begin
                    launch      = 1'b1;
                    launch_data = init_word;
                    init_step   = 1'b1;
                end else if (req) begin
                    launch      = 1'b1;
                    launch_data = lcd_reg_i[7:0];
                    launch_rs   = lcd_reg_i[8];
                    req_taken   = 1'b1;
                end
            end
            SETUP: begin
                if (last_cycle) begin
                    state_d = PULSE;
                    cnt_d   = T_EN_HIGH;
                end
            end
            PULSE: begin
                if (last_cycle) begin
                    state_d = HOLD;
                    cnt_d   = T_HOLD;
                end
            end
            HOLD: begin
                if (last_cycle) begin
                    state_d = EXEC;
                    cnt_d   = exec_len(rs_q, data_q);
                end
            end
            EXEC: begin
                if (last_cycle) begin
                    // Init words take priority; host requests stay pending until the sequence ends.
                    if (init_rem) begin
                        launch      = 1'b1;
                        launch_data = init_word;
                        init_step   = 1'b1;
                    end else if (pend_vld_q) begin
                        launch      = 1'b1;
                        launch_data = pend_data_q;
                        launch_rs   = pend_rs_q;
                        pend_vld_d  = 1'b0;
                    end else if (req) begin
                        launch      = 1'b1;
                        launch_data = lcd_reg_i[7:0];
                        launch_rs   = lcd_reg_i[8];
                        req_taken   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = SETUP;
            cnt_d   = T_SETUP;
            data_d  = launch_data;
            rs_d    = launch_rs;
        end

        // A slot freed this cycle by a launch refills without counting as overrun.
        if (req && !req_taken) begin
            ovr_d       = ovr_q | pend_vld_d;
            pend_vld_d  = 1'b1;
            pend_data_d = lcd_reg_i[7:0];
            pend_rs_d   = lcd_reg_i[8];
        end

        en_d   = (state_d == PULSE);
        busy_d = (state_d != IDLE) || pend_vld_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            on_q        <= 1'b0;
            prev_go_q   <= lcd_reg_i[10];
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_rs_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            on_q        <= lcd_reg_i[31];
            prev_go_q   <= lcd_reg_i[10];
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_rs_q   <= pend_rs_d;
        end
    end

    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_on_o   = on_q;
    assign busy_o     = busy_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: vector table plus an EN-pulse scoreboard.
module tb_lcd_ctrl;

    logic        clk;
    logic        rst_ni;
    logic [31:0] lcd_reg_i;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_en_o;
    logic        lcd_on_o;
    logic        busy_o;
    logic        overrun_o;

    lcd_ctrl #(
        .T_SETUP    (2),
        .T_EN_HIGH  (4),
        .T_HOLD     (2),
        .T_EXEC     (10),
        .T_EXEC_LONG(30)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .lcd_reg_i (lcd_reg_i),
        .lcd_data_o(lcd_data_o),
        .lcd_rs_o  (lcd_rs_o),
        .lcd_rw_o  (lcd_rw_o),
        .lcd_en_o  (lcd_en_o),
        .lcd_on_o  (lcd_on_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [8:0] exp_q[$];
    logic       mon_prev_en = 1'b0;

    logic       go = 1'b0;
    logic       on = 1'b1;
    logic [7:0] cur_data = '0;
    logic       cur_rs = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        rs;
        int unsigned busy_len;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd();
        lcd_reg_i = {on, 20'b0, go, 1'b0, cur_rs, cur_data};
    endtask

    task automatic issue(input logic [7:0] d, input logic r, input logic push);
        go       = ~go;
        cur_data = d;
        cur_rs   = r;
        upd();
        if (push) exp_q.push_back({r, d});
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Scoreboard: every EN rising edge must carry the oldest expected word.
    always @(negedge clk) begin
        if (lcd_en_o && !mon_prev_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_pulse: got word 0x%0h, expected no pulse at %0t",
                         {lcd_rs_o, lcd_data_o}, $time);
            end else begin
                check("sb_pulse_word", {23'b0, lcd_rs_o, lcd_data_o}, {23'b0, exp_q.pop_front()});
            end
        end
        mon_prev_en = lcd_en_o;
    end

    int unsigned en_bad, busy_bad, rw_bad, rises, hi_cnt;
    logic        prev_en;

    initial begin
        vecs[0] = '{8'h41, 1'b1, 18};
        vecs[1] = '{8'h01, 1'b0, 38};
        vecs[2] = '{8'h02, 1'b0, 38};
        vecs[3] = '{8'h03, 1'b0, 38};
        vecs[4] = '{8'h01, 1'b1, 18};
        vecs[5] = '{8'h04, 1'b0, 18};
        vecs[6] = '{8'h00, 1'b0, 18};
        vecs[7] = '{8'hFF, 1'b1, 18};

        rst_ni = 1'b0;
        go     = 1'b1;
        upd();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'b0, lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o,
                                busy_o, overrun_o}, 32'h0);

`ifdef LCD_CTRL_INIT_SEQ_EN
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        @(posedge clk); #1 rst_ni = 1'b1;
        busy_bad = 0; rises = 0; prev_en = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k <= 88 && !busy_o) busy_bad++;
            if (lcd_en_o && !prev_en) rises++;
            prev_en = lcd_en_o;
        end
        check("init_busy_held", busy_bad, 0);
        check("init_pulse_count", rises, 4);
        check("init_busy_done", {31'b0, busy_o}, 32'h0);
`else
        // Quiet period after release: GO held constant, no transfer may start.
        @(posedge clk); #1 rst_ni = 1'b1;
        hi_cnt = 0; busy_bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (lcd_en_o) hi_cnt++;
            if (busy_o) busy_bad++;
        end
        check("quiet_en", hi_cnt, 0);
        check("quiet_busy", busy_bad, 0);
        check("quiet_data_rs_ovr", {22'b0, lcd_data_o, lcd_rs_o, overrun_o}, 32'h0);
        check("on_follows", {31'b0, lcd_on_o}, 32'h1);
        @(posedge clk); #1 on = 1'b0; upd();
        @(negedge clk);
        check("on_latency_old", {31'b0, lcd_on_o}, 32'h1);
        @(negedge clk);
        check("on_latency_new", {31'b0, lcd_on_o}, 32'h0);
        @(posedge clk); #1 on = 1'b1; upd();
        @(negedge clk);

        // Single transfers from the vector table.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            issue(vecs[i].data, vecs[i].rs, 1'b1);
            @(negedge clk);
            check("vec_busy_at_n", {31'b0, busy_o}, 32'h0);
            en_bad = 0; busy_bad = 0; rw_bad = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == 1) check("vec_data_rs_n1", {23'b0, lcd_rs_o, lcd_data_o},
                                  {23'b0, vecs[i].rs, vecs[i].data});
                if (lcd_en_o != (k >= 3 && k <= 6)) en_bad++;
                if (busy_o != (k <= int'(vecs[i].busy_len))) busy_bad++;
                if (lcd_rw_o) rw_bad++;
            end
            check("vec_en_window", en_bad, 0);
            check("vec_busy_window", busy_bad, 0);
            check("vec_rw_low", rw_bad, 0);
        end

        // Three requests during one transfer: middle one is dropped.
        rises = 0; prev_en = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 0) issue(8'h41, 1'b1, 1'b1);
            if (k == 3) issue(8'h42, 1'b1, 1'b0);
            if (k == 5) issue(8'h43, 1'b1, 1'b1);
            @(negedge clk);
            if (lcd_en_o && !prev_en) rises++;
            prev_en = lcd_en_o;
        end
        check("ovr_pulse_count", rises, 2);
        check("ovr_sticky", {31'b0, overrun_o}, 32'h1);
        check("ovr_busy_done", {31'b0, busy_o}, 32'h0);

        // Pending consumed on last EXEC cycle while a new request refills it.
        do_reset();
        check("reset_clears_ovr", {31'b0, overrun_o}, 32'h0);
        en_bad = 0; busy_bad = 0;
        for (int k = 0; k <= 70; k++) begin
            @(posedge clk); #1;
            if (k == 0)  issue(8'h50, 1'b1, 1'b1);
            if (k == 5)  issue(8'h51, 1'b1, 1'b1);
            if (k == 18) issue(8'h52, 1'b0, 1'b1);
            @(negedge clk);
            if (lcd_en_o != ((k >= 3 && k <= 6) || (k >= 21 && k <= 24) ||
                             (k >= 39 && k <= 42))) en_bad++;
            if (busy_o != (k >= 1 && k <= 54)) busy_bad++;
        end
        check("refill_en_window", en_bad, 0);
        check("refill_busy_window", busy_bad, 0);
        check("refill_no_ovr", {31'b0, overrun_o}, 32'h0);

        // Request on last EXEC cycle with empty pending is taken directly.
        en_bad = 0; busy_bad = 0;
        for (int k = 0; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 0)  issue(8'h60, 1'b1, 1'b1);
            if (k == 18) issue(8'h61, 1'b1, 1'b1);
            @(negedge clk);
            if (lcd_en_o != ((k >= 3 && k <= 6) || (k >= 21 && k <= 24))) en_bad++;
            if (busy_o != (k >= 1 && k <= 36)) busy_bad++;
        end
        check("direct_en_window", en_bad, 0);
        check("direct_busy_window", busy_bad, 0);

        // Reset asserted during PULSE aborts the transfer.
        hi_cnt = 0;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) issue(8'h70, 1'b1, 1'b1);
            if (k == 4) rst_ni = 1'b0;
            if (k == 6) rst_ni = 1'b1;
            @(negedge clk);
            if (k == 4) check("abort_en_before", {31'b0, lcd_en_o}, 32'h1);
            if (k == 5) check("abort_en_busy_after", {30'b0, lcd_en_o, busy_o}, 32'h0);
            if (k >= 7 && (lcd_en_o || busy_o)) hi_cnt++;
        end
        check("abort_no_spurious", hi_cnt, 0);
`endif

        check("sb_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
